// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencer for the RV32I core. Walks each instruction through
//   FETCH/DECODE/EXEC/(MEM)/WB and issues one-cycle enables to the datapath.
//   Memory waits are bounded by TIMEOUT; illegal opcodes and timeouts park the
//   controller in an absorbing TRAP state until rst_n.
//
//   Ports
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     run               level enable, sampled in IDLE and WB
//     imem_ready        instruction memory data valid this cycle
//     dmem_ready        data memory access completes this cycle
//     regWrite, MemRead, MemWrite, BranchSig, Jump
//                       decoded control bundle, sampled in EXEC
//     branch_taken      comparator result / JAL marker, sampled in EXEC
//     illegal           decoded opcode outside RV32I, sampled in DECODE
//     imem_req, ir_we   fetch request and instruction-register latch
//     pc_we, pc_sel     PC update and source (0=PC+4, 1=branch/JAL, 2=JALR)
//     dmem_req, dmem_we data memory request and write qualifier
//     rf_we             register file write enable
//     state             current state encoding (debug)
//     trap, trap_cause  sticky error flag and cause (1=illegal, 2=imem, 3=dmem)
//     retired           retired-instruction counter (wraps)
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             regWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             BranchSig,
    input  logic             Jump,
    input  logic             branch_taken,
    input  logic             illegal,
    output logic             imem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [2:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam int unsigned WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t          cur, nxt;
    logic [WC_W-1:0] wcnt;
    logic [1:0]      cause_d;
    // Control bundle captured at the end of EXEC; MEM and WB use only these.
    logic            l_rw, l_mw, l_br, l_jp, l_bt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= S_IDLE;
            wcnt       <= '0;
            trap_cause <= '0;
            retired    <= '0;
            l_rw       <= 1'b0;
            l_mw       <= 1'b0;
            l_br       <= 1'b0;
            l_jp       <= 1'b0;
            l_bt       <= 1'b0;
        end else begin
            cur        <= nxt;
            trap_cause <= cause_d;
            // Counter tracks cycles spent in the current FETCH/MEM visit only.
            if (nxt != cur)
                wcnt <= '0;
            else if (cur == S_FETCH || cur == S_MEM)
                wcnt <= wcnt + 1'b1;
            else
                wcnt <= '0;
            if (cur == S_EXEC) begin
                l_rw <= regWrite;
                l_mw <= MemWrite;
                l_br <= BranchSig;
                l_jp <= Jump;
                l_bt <= branch_taken;
            end
            if (cur == S_WB)
                retired <= retired + 1'b1;
        end
    end

    always_comb begin
        nxt      = cur;
        cause_d  = trap_cause;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'd0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        case (cur)
            S_IDLE: begin
                if (run) nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we = 1'b1;
                    nxt   = S_DECODE;
                end else if (wcnt == WC_LAST) begin
                    nxt     = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    nxt     = S_TRAP;
                    cause_d = 2'd1;
                end else begin
                    nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // A simultaneous load+store is an undecodable bundle.
                if (MemRead && MemWrite) begin
                    nxt     = S_TRAP;
                    cause_d = 2'd1;
                end else if (MemRead || MemWrite) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = l_mw;
                if (dmem_ready) begin
                    nxt = S_WB;
                end else if (wcnt == WC_LAST) begin
                    nxt     = S_TRAP;
                    cause_d = 2'd3;
                end
            end
            S_WB: begin
                rf_we = l_rw;
                pc_we = 1'b1;
                // For jumps the datapath marks JAL with branch_taken=1; JALR otherwise.
                if (l_jp)
                    pc_sel = l_bt ? 2'd1 : 2'd2;
                else if (l_br && l_bt)
                    pc_sel = 2'd1;
                nxt = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                nxt = S_TRAP;
            end
            default: begin
                nxt = S_IDLE;
            end
        endcase
    end

    assign state = cur;
    assign trap  = (cur == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        regWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        BranchSig = 1'b0, Jump = 1'b0, branch_taken = 1'b0, illegal = 1'b0;
    logic        imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we, trap;
    logic [1:0]  pc_sel, trap_cause;
    logic [2:0]  state;
    logic [31:0] retired;

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .regWrite(regWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .BranchSig(BranchSig), .Jump(Jump), .branch_taken(branch_taken),
        .illegal(illegal),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
        .state(state), .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic run, imr, dmr, rw, mr, mw, br, jp, bt, ill;
    } in_t;

    typedef struct {
        in_t         i;
        logic [45:0] x;
    } cyc_t;

    cyc_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_ret = 0;
    logic [45:0] obs;

    assign obs = {state, imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we,
                  rf_we, trap, trap_cause, retired};

    // Expected observation vector for one cycle, using the model's retired count.
    function automatic logic [45:0] ex(input logic [2:0] st, input logic ireq, irwe, pcwe,
                                       input logic [1:0] psel, input logic dreq, dwe, rfwe,
                                       input logic [1:0] cause);
        return {st, ireq, irwe, pcwe, psel, dreq, dwe, rfwe, (st == 3'd6), cause, m_ret};
    endfunction

    // Random don't-care inputs with the given run level and illegal low.
    function automatic in_t rin(input logic r);
        logic [9:0] v;
        in_t        t;
        v = 10'($urandom);
        t = v;
        t.run = r;
        t.ill = 1'b0;
        return t;
    endfunction

    task automatic push(input in_t i, input logic [45:0] x);
        cyc_t c;
        c.i = i;
        c.x = x;
        sb.push_back(c);
    endtask

    task automatic apply_next(output cyc_t c);
        c = sb.pop_front();
        @(negedge clk);
        run = c.i.run; imem_ready = c.i.imr; dmem_ready = c.i.dmr;
        regWrite = c.i.rw; MemRead = c.i.mr; MemWrite = c.i.mw;
        BranchSig = c.i.br; Jump = c.i.jp; branch_taken = c.i.bt; illegal = c.i.ill;
        #1;
    endtask

    // Optional IDLE cycle, iw unanswered fetch cycles, then the fetch hit.
    task automatic push_head(input bit from_idle, input int iw, input logic run_mid);
        in_t i;
        if (from_idle) begin
            i = rin(1'b1);
            push(i, ex(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        end
        for (int k = 0; k < iw; k++) begin
            i = rin(run_mid); i.imr = 1'b0;
            push(i, ex(3'd1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        end
        i = rin(run_mid); i.imr = 1'b1;
        push(i, ex(3'd1, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0));
    endtask

    task automatic push_instr(input bit from_idle, input int iw,
                              input logic rw, mr, mw, br, jp, bt,
                              input int dw, input logic run_mid, run_wb);
        in_t        i;
        logic [1:0] psel;
        push_head(from_idle, iw, run_mid);
        i = rin(run_mid);
        push(i, ex(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        i = rin(run_mid);
        {i.rw, i.mr, i.mw, i.br, i.jp, i.bt} = {rw, mr, mw, br, jp, bt};
        push(i, ex(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        if (mr || mw) begin
            for (int k = 0; k <= dw; k++) begin
                i = rin(run_mid); i.dmr = (k == dw);
                push(i, ex(3'd4, 0, 0, 0, 2'd0, 1, mw, 0, 2'd0));
            end
        end
        if ((br && bt) || (jp && bt)) psel = 2'd1;
        else if (jp)                  psel = 2'd2;
        else                          psel = 2'd0;
        i = rin(run_wb);
        push(i, ex(3'd5, 0, 0, 1, psel, 0, 0, rw, 2'd0));
        m_ret = m_ret + 1;
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++)
            push(rin(1'b0), ex(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
    endtask

    task automatic push_trap(input int n, input logic [1:0] cause);
        in_t i;
        for (int k = 0; k < n; k++) begin
            i = rin($urandom_range(0, 1) == 1);
            i.ill = $urandom_range(0, 1) == 1;
            push(i, ex(3'd6, 0, 0, 0, 2'd0, 0, 0, 0, cause));
        end
    endtask

    task automatic test_reset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        {run, imem_ready, dmem_ready, regWrite, MemRead, MemWrite} = '0;
        {BranchSig, Jump, branch_taken, illegal} = '0;
        m_ret = 0;
        #1;
        total++;
        if (obs !== ex(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0)) begin
            bad++;
            $display("FAIL reset_%s: got %h want %h", name, obs,
                     ex(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu;
        cyc_t c;
        push_instr(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        push_idle(2);
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL alu: state=%0d got %h want %h", state, obs, c.x);
            end
        end
    endtask

    task automatic test_load;
        cyc_t c;
        push_instr(1, 2, 1, 1, 0, 0, 0, 0, 2, 1, 0);
        push_idle(1);
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL load: state=%0d got %h want %h", state, obs, c.x);
            end
        end
    endtask

    task automatic test_back_to_back;
        cyc_t c;
        push_instr(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1);   // store
        push_instr(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 1);   // taken branch
        push_instr(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);   // untaken branch
        push_instr(0, 15, 1, 0, 0, 0, 1, 1, 0, 1, 1);  // JAL, last fetch cycle before timeout
        push_instr(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1);   // JALR
        push_instr(0, 0, 1, 1, 0, 0, 0, 0, 15, 1, 0);  // load, last MEM cycle before timeout
        push_idle(1);
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL back_to_back: state=%0d got %h want %h", state, obs, c.x);
            end
        end
    endtask

    task automatic test_run_drop;
        cyc_t c;
        push_instr(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        push_idle(3);
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL run_drop: state=%0d got %h want %h", state, obs, c.x);
            end
        end
    endtask

    task automatic test_illegal;
        cyc_t c;
        in_t  i;
        push_head(1, 0, 1'b1);
        i = rin(1'b1); i.ill = 1'b1; i.mr = 1'b1; i.rw = 1'b1;
        push(i, ex(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        push_trap(6, 2'd1);
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL illegal: state=%0d got %h want %h", state, obs, c.x);
            end
        end
    endtask

    task automatic test_both_mem;
        cyc_t c;
        in_t  i;
        push_head(1, 0, 1'b1);
        push(rin(1'b1), ex(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        i = rin(1'b1); i.mr = 1'b1; i.mw = 1'b1;
        push(i, ex(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        push_trap(3, 2'd1);
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL both_mem: state=%0d got %h want %h", state, obs, c.x);
            end
        end
    endtask

    task automatic test_imem_timeout;
        cyc_t c;
        in_t  i;
        push(rin(1'b1), ex(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        for (int k = 0; k < 16; k++) begin
            i = rin(1'b1); i.imr = 1'b0;
            push(i, ex(3'd1, 1, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        end
        push_trap(3, 2'd2);
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL imem_timeout: state=%0d got %h want %h", state, obs, c.x);
            end
        end
    endtask

    task automatic test_dmem_timeout;
        cyc_t c;
        in_t  i;
        push_instr(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);    // one ALU op so retired is nonzero
        push_head(0, 0, 1'b1);
        push(rin(1'b1), ex(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        i = rin(1'b1); i.mr = 1'b0; i.mw = 1'b1;
        push(i, ex(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        for (int k = 0; k < 16; k++) begin
            i = rin(1'b1); i.dmr = 1'b0;
            push(i, ex(3'd4, 0, 0, 0, 2'd0, 1, 1, 0, 2'd0));
        end
        push_trap(3, 2'd3);
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL dmem_timeout: state=%0d got %h want %h", state, obs, c.x);
            end
        end
    endtask

    task automatic test_mem_abort;
        cyc_t c;
        in_t  i;
        push_instr(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        push_head(0, 0, 1'b1);
        push(rin(1'b1), ex(3'd2, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        i = rin(1'b1); i.mr = 1'b1; i.mw = 1'b0; i.rw = 1'b1;
        push(i, ex(3'd3, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0));
        for (int k = 0; k < 2; k++) begin
            i = rin(1'b1); i.dmr = 1'b0;
            push(i, ex(3'd4, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0));
        end
        while (sb.size() > 0) begin
            apply_next(c);
            total++;
            if (obs !== c.x) begin
                bad++;
                $display("FAIL mem_abort: state=%0d got %h want %h", state, obs, c.x);
            end
        end
        // Reset lands mid-wait in MEM, between clock edges.
        test_reset("mid_mem");
    endtask

    initial begin
        test_reset("power_on");
        test_alu();
        test_load();
        test_back_to_back();
        test_run_drop();
        test_illegal();
        test_reset("after_illegal");
        test_both_mem();
        test_reset("after_both_mem");
        test_imem_timeout();
        test_reset("after_imem_timeout");
        test_dmem_timeout();
        test_reset("after_dmem_timeout");
        test_mem_abort();
        test_alu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
